// File: rtl/queue_pkg.sv
// queue_pkg: shared sizing and types for the byte_queue slice.
//   QUEUE_DEPTH - default number of FIFO entries
//   DATA_W      - default data width
//   byte_t      - one queue entry
//   len_t       - occupancy count, wide enough to hold 0..QUEUE_DEPTH
package queue_pkg;

    localparam int QUEUE_DEPTH = 8;
    localparam int DATA_W      = 8;
    localparam int LEN_W       = $clog2(QUEUE_DEPTH + 1);

    typedef logic [DATA_W-1:0] byte_t;
    typedef logic [LEN_W-1:0]  len_t;

endpackage

// File: rtl/rise_detect.sv
// rise_detect: registered 0->1 edge detector for a level request input.
//   clock_1MHz - clock
//   rst        - asynchronous active-high reset
//   in         - level input, synchronous to clock_1MHz
//   rise       - high for the cycle in which 'in' is high and was low last cycle
// The history flop resets low, so an input already high at the first edge
// after reset counts as a rising edge.
module rise_detect (
    input  logic clock_1MHz,
    input  logic rst,
    input  logic in,
    output logic rise
);

    logic in_q;

    always_ff @(posedge clock_1MHz or posedge rst) begin
        if (rst) in_q <= 1'b0;
        else     in_q <= in;
    end

    assign rise = in & ~in_q;

endmodule

// File: rtl/byte_queue.sv
// byte_queue: DEPTH-entry FIFO fed by rising edges of level request pulses.
//   clock_1MHz - clock, all state changes on rising edge
//   rst        - asynchronous active-high reset
//   data_in    - byte to store, sampled on the enqueue rising-edge cycle
//   enqueue_in - enqueue request level, acted on at 0->1
//   dequeue_in - dequeue request level, acted on at 0->1
//   data_out   - last dequeued byte, held until next successful dequeue
//   len_out    - occupancy 0..DEPTH
//   empty_out  - len_out == 0
//   full_out   - len_out == DEPTH
//   error_out  - one-cycle pulse on overflow or underflow
module byte_queue
    import queue_pkg::*;
#(
    parameter int DEPTH = QUEUE_DEPTH,
    parameter int WIDTH = DATA_W
) (
    input  logic                       clock_1MHz,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       enqueue_in,
    input  logic                       dequeue_in,
    output logic [WIDTH-1:0]           data_out,
    output logic [$clog2(DEPTH+1)-1:0] len_out,
    output logic                       empty_out,
    output logic                       full_out,
    output logic                       error_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic             enq_rise, deq_rise;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    len;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             empty, full;
    logic             do_enq, do_deq, reject;

    rise_detect u_enq_rise (
        .clock_1MHz (clock_1MHz),
        .rst        (rst),
        .in         (enqueue_in),
        .rise       (enq_rise)
    );

    rise_detect u_deq_rise (
        .clock_1MHz (clock_1MHz),
        .rst        (rst),
        .in         (dequeue_in),
        .rise       (deq_rise)
    );

    assign empty = (len == LW'(0));
    assign full  = (len == LW'(DEPTH));

    // A dequeue on an empty queue is never bypassed to the incoming byte.
    // An enqueue on a full queue succeeds only if a dequeue frees the head
    // slot in the same cycle; wr_ptr == rd_ptr then, and the old head is
    // read out before the new byte lands in that slot.
    assign do_deq = deq_rise & ~empty;
    assign do_enq = enq_rise & (~full | deq_rise);
    assign reject = (enq_rise & full & ~deq_rise) | (deq_rise & empty & ~enq_rise);

    always_ff @(posedge clock_1MHz or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            len       <= '0;
            data_out  <= '0;
            error_out <= 1'b0;
        end else begin
            error_out <= reject;
            if (do_enq) wr_ptr <= wr_ptr + PW'(1);
            if (do_deq) begin
                rd_ptr   <= rd_ptr + PW'(1);
                data_out <= mem[rd_ptr];
            end
            len <= len + LW'(do_enq) - LW'(do_deq);
        end
    end

    // Storage is not reset; contents are meaningless once pointers clear.
    always_ff @(posedge clock_1MHz) begin
        if (do_enq) mem[wr_ptr] <= data_in;
    end

    assign len_out   = len;
    assign empty_out = empty;
    assign full_out  = full;

endmodule

// File: tb/tb_byte_queue.sv
// tb_byte_queue: directed vector table, reset-mid-operation sequence and a
// randomized phase checked against a queue-based reference model.
module tb_byte_queue;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       enqueue_in, dequeue_in;
    logic [7:0] data_out;
    logic [3:0] len_out;
    logic       empty_out, full_out, error_out;

    byte_queue #(.DEPTH(DEPTH), .WIDTH(8)) dut (
        .clock_1MHz (clk),
        .rst        (rst),
        .data_in    (data_in),
        .enqueue_in (enqueue_in),
        .dequeue_in (dequeue_in),
        .data_out   (data_out),
        .len_out    (len_out),
        .empty_out  (empty_out),
        .full_out   (full_out),
        .error_out  (error_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         enq;
        bit         deq;
        logic [7:0] din;
        logic [7:0] dout;
        logic [3:0] len;
        bit         err;
    } vec_t;

    vec_t vecs[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic void add(bit e, bit d, logic [7:0] di, logic [7:0] dout,
                                int len, bit err);
        vec_t v;
        v.enq = e; v.deq = d; v.din = di; v.dout = dout; v.len = 4'(len); v.err = err;
        vecs.push_back(v);
    endfunction

    // Compare all outputs at once; empty/full follow from the expected length.
    task automatic check(string name, logic [7:0] dout, logic [3:0] len, bit err);
        logic [14:0] got, exp;
        got = {data_out, len_out, empty_out, full_out, error_out};
        exp = {dout, len, (len == 4'd0), (len == 4'(DEPTH)), err};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got dout=%h len=%0d empty=%b full=%b err=%b, want dout=%h len=%0d empty=%b full=%b err=%b",
                     name, data_out, len_out, empty_out, full_out, error_out,
                     dout, len, (len == 4'd0), (len == 4'(DEPTH)), err);
        end
    endtask

    // Drive at the falling edge, let the rising edge act, sample 1 time unit later.
    task automatic step(bit e, bit d, logic [7:0] di);
        @(negedge clk);
        enqueue_in = e;
        dequeue_in = d;
        data_in    = di;
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain queue plus previous request levels.
    logic [7:0] mq[$];
    logic [7:0] mdout;
    bit         mpe, mpd, merr;

    function automatic void model(bit e, bit d, logic [7:0] di);
        bit er, dr;
        er = e & ~mpe;
        dr = d & ~mpd;
        mpe = e;
        mpd = d;
        merr = 1'b0;
        if (er && dr) begin
            if (mq.size() != 0) mdout = mq.pop_front();
            mq.push_back(di);
        end else if (er) begin
            if (mq.size() == DEPTH) merr = 1'b1;
            else mq.push_back(di);
        end else if (dr) begin
            if (mq.size() == 0) merr = 1'b1;
            else mdout = mq.pop_front();
        end
    endfunction

    initial begin
        rst = 1'b1;
        enqueue_in = 1'b0;
        dequeue_in = 1'b0;
        data_in = 8'h00;

        // reset then idle
        for (int i = 0; i < 10; i++) add(0, 0, 8'h00, 8'h00, 0, 0);
        // held enqueue of AA, then held dequeue: one action each
        for (int i = 0; i < 10; i++) add(1, 0, 8'hAA, 8'h00, 1, 0);
        add(0, 0, 8'hAA, 8'h00, 1, 0);
        for (int i = 0; i < 10; i++) add(0, 1, 8'h00, 8'hAA, 0, 0);
        add(0, 0, 8'h00, 8'hAA, 0, 0);
        // fill, overflow, drain, underflow
        for (int i = 1; i <= 8; i++) begin
            add(1, 0, 8'(i), 8'hAA, i, 0);
            add(0, 0, 8'(i), 8'hAA, i, 0);
        end
        add(1, 0, 8'hFF, 8'hAA, 8, 1);
        add(0, 0, 8'hFF, 8'hAA, 8, 0);
        for (int i = 1; i <= 8; i++) begin
            add(0, 1, 8'h00, 8'(i), 8 - i, 0);
            add(0, 0, 8'h00, 8'(i), 8 - i, 0);
        end
        add(0, 1, 8'h00, 8'h08, 0, 1);
        add(0, 0, 8'h00, 8'h08, 0, 0);
        // wrap-around
        for (int i = 0; i < 5; i++) begin
            add(1, 0, 8'hA0 + 8'(i), 8'h08, i + 1, 0);
            add(0, 0, 8'h00, 8'h08, i + 1, 0);
        end
        for (int i = 0; i < 5; i++) begin
            add(0, 1, 8'h00, 8'hA0 + 8'(i), 4 - i, 0);
            add(0, 0, 8'h00, 8'hA0 + 8'(i), 4 - i, 0);
        end
        for (int i = 0; i < 6; i++) begin
            add(1, 0, 8'h10 + 8'(i), 8'hA4, i + 1, 0);
            add(0, 0, 8'h00, 8'hA4, i + 1, 0);
        end
        for (int i = 0; i < 6; i++) begin
            add(0, 1, 8'h00, 8'h10 + 8'(i), 5 - i, 0);
            add(0, 0, 8'h00, 8'h10 + 8'(i), 5 - i, 0);
        end
        // simultaneous edges on an empty queue: enqueue only, no error
        add(1, 1, 8'h33, 8'h15, 1, 0);
        add(0, 0, 8'h33, 8'h15, 1, 0);
        add(0, 1, 8'h00, 8'h33, 0, 0);
        add(0, 0, 8'h00, 8'h33, 0, 0);
        // simultaneous edges on a full queue: head out, new byte in last
        for (int i = 1; i <= 8; i++) begin
            add(1, 0, 8'(i), 8'h33, i, 0);
            add(0, 0, 8'(i), 8'h33, i, 0);
        end
        add(1, 1, 8'h99, 8'h01, 8, 0);
        add(0, 0, 8'h99, 8'h01, 8, 0);
        for (int k = 2; k <= 8; k++) begin
            add(0, 1, 8'h00, 8'(k), 9 - k, 0);
            add(0, 0, 8'h00, 8'(k), 9 - k, 0);
        end
        add(0, 1, 8'h00, 8'h99, 0, 0);
        add(0, 0, 8'h00, 8'h99, 0, 0);

        // release reset away from an edge
        @(negedge clk);
        #1;
        check("reset_state", 8'h00, 4'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].enq, vecs[i].deq, vecs[i].din);
            check($sformatf("vec%0d", i), vecs[i].dout, vecs[i].len, vecs[i].err);
        end

        // reset mid-operation: outputs clear without a clock edge
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 8'hC0 + 8'(i));
            step(0, 0, 8'h00);
        end
        check("pre_reset_len", 8'h99, 4'd3, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", 8'h00, 4'd0, 1'b0);
        @(posedge clk);
        #1;
        check("reset_held", 8'h00, 4'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 8'h5A);
        check("post_reset_enq", 8'h00, 4'd1, 1'b0);
        step(0, 0, 8'h00);
        step(0, 1, 8'h00);
        check("post_reset_deq", 8'h5A, 4'd0, 1'b0);
        step(0, 0, 8'h00);

        // randomized phase, biased toward filling then draining
        mq.delete();
        mdout = 8'h5A;
        mpe = 1'b0;
        mpd = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            bit e, d;
            logic [7:0] di;
            int bias;
            bias = ((i / 150) % 2 == 0) ? 60 : 25;
            e  = ($urandom_range(0, 99) < bias);
            d  = ($urandom_range(0, 99) < (85 - bias));
            di = 8'($urandom);
            step(e, d, di);
            model(e, d, di);
            check($sformatf("rand%0d", i), mdout, 4'(mq.size()), merr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
